// File: rtl/scan_sequencer.sv
// scan_sequencer: registered 3-bit decoder select generator with a prescaler and up/down/ping-pong/hold modes.
// Build option SCAN_SKIP_EN adds skip_mask so that a tick jumps over masked codes.
module scan_sequencer #(
    parameter int DIV = 4,
    parameter int PW  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       load,
    input  logic [2:0] load_val,
`ifdef SCAN_SKIP_EN
    input  logic [7:0] skip_mask,
`endif
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       step,
    output logic       wrap,
    output logic       dbg_dir
);

    // DIV of 0 or 1 both mean a tick on every enabled cycle.
    localparam logic [PW-1:0] CNT_LAST = (DIV <= 1) ? '0 : PW'(DIV - 1);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    typedef struct packed {
        logic [2:0] sel;
        dir_t       dir;
        logic       wrap;
    } nxt_t;

    logic [PW-1:0] cnt_q, cnt_d;
    logic [2:0]    sel_q, sel_d;
    dir_t          dir_q, dir_d;
    logic          step_q, step_d;
    logic          wrap_q, wrap_d;
    logic          tick;
    nxt_t          nxt;

    // One position of movement under the mode rules; ping-pong reverses when leaving an endpoint.
    function automatic nxt_t advance(input logic [2:0] sel, input dir_t dir, input logic [1:0] md);
        nxt_t r;
        r.sel  = sel;
        r.dir  = dir;
        r.wrap = 1'b0;
        case (md)
            2'b00: begin
                r.sel  = sel + 3'd1;
                r.dir  = DIR_UP;
                r.wrap = (sel == 3'd7);
            end
            2'b01: begin
                r.sel  = sel - 3'd1;
                r.dir  = DIR_DOWN;
                r.wrap = (sel == 3'd0);
            end
            2'b10: begin
                if (dir == DIR_UP) begin
                    if (sel == 3'd7) begin
                        r.sel = 3'd6;
                        r.dir = DIR_DOWN;
                    end else begin
                        r.sel = sel + 3'd1;
                    end
                end else begin
                    if (sel == 3'd0) begin
                        r.sel = 3'd1;
                        r.dir = DIR_UP;
                    end else begin
                        r.sel  = sel - 3'd1;
                        r.wrap = (sel == 3'd1);
                    end
                end
            end
            default: ;
        endcase
        return r;
    endfunction

`ifdef SCAN_SKIP_EN
    nxt_t walk;
    logic hit;
    logic wrap_acc;

    // Walk up to seven positions and land on the first unmasked code; wrap if any hop crossed the end.
    always_comb begin
        walk.sel  = sel_q;
        walk.dir  = dir_q;
        walk.wrap = 1'b0;
        nxt.sel   = sel_q;
        nxt.dir   = dir_q;
        nxt.wrap  = 1'b0;
        hit       = 1'b0;
        wrap_acc  = 1'b0;
        for (int i = 0; i < 7; i++) begin
            walk     = advance(walk.sel, walk.dir, mode);
            wrap_acc = wrap_acc | walk.wrap;
            if (!hit && !skip_mask[walk.sel]) begin
                hit      = 1'b1;
                nxt.sel  = walk.sel;
                nxt.dir  = walk.dir;
                nxt.wrap = wrap_acc;
            end
        end
    end
`else
    always_comb begin
        nxt = advance(sel_q, dir_q, mode);
    end
`endif

    always_comb begin
        tick   = en && (cnt_q == CNT_LAST);
        cnt_d  = cnt_q;
        sel_d  = sel_q;
        dir_d  = dir_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
        if (load) begin
            sel_d = load_val;
            cnt_d = '0;
            dir_d = (load_val == 3'd7) ? DIR_DOWN : DIR_UP;
        end else begin
            if (en) begin
                cnt_d = tick ? '0 : cnt_q + PW'(1);
            end
            if (tick) begin
                sel_d  = nxt.sel;
                dir_d  = nxt.dir;
                step_d = 1'b1;
                wrap_d = nxt.wrap;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            sel_q  <= 3'd0;
            dir_q  <= DIR_UP;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sel_q  <= sel_d;
            dir_q  <= dir_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    assign s0      = sel_q[0];
    assign s1      = sel_q[1];
    assign s2      = sel_q[2];
    assign step    = step_q;
    assign wrap    = wrap_q;
    assign dbg_dir = dir_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: two instances (DIV=4 and DIV=1) compared every cycle against a phase-based model.
module tb_scan_sequencer;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [2:0] load_val;
`ifdef SCAN_SKIP_EN
    logic [7:0] skip_mask;
`endif
    logic       s0_a, s1_a, s2_a, step_a, wrap_a, dir_a;
    logic       s0_b, s1_b, s2_b, step_b, wrap_b, dir_b;

    int n_checks = 0;
    int n_errors = 0;

    int m_sel[2];
    bit m_dir[2];
    bit m_step[2];
    bit m_wrap[2];
    int m_cnt[2];
    int m_div[2] = '{4, 1};

    scan_sequencer #(.DIV(4), .PW(16)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
`ifdef SCAN_SKIP_EN
        .skip_mask(skip_mask),
`endif
        .s0(s0_a), .s1(s1_a), .s2(s2_a), .step(step_a), .wrap(wrap_a), .dbg_dir(dir_a)
    );

    scan_sequencer #(.DIV(1), .PW(16)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
`ifdef SCAN_SKIP_EN
        .skip_mask(skip_mask),
`endif
        .s0(s0_b), .s1(s1_b), .s2(s2_b), .step(step_b), .wrap(wrap_b), .dbg_dir(dir_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ping-pong is a 14-phase loop 0..7..1; dir is DOWN on phases 8..13 and on phase 0.
    task automatic ref_step(input int sel, input bit dir, input logic [1:0] md,
                            output int nsel, output bit ndir, output bit nwrap);
        int ph;
        nsel  = sel;
        ndir  = dir;
        nwrap = 1'b0;
        case (md)
            2'b00: begin nsel = (sel + 1) % 8; ndir = 1'b0; nwrap = (nsel == 0); end
            2'b01: begin nsel = (sel + 7) % 8; ndir = 1'b1; nwrap = (nsel == 7); end
            2'b10: begin
                ph    = (dir == 1'b0 || sel == 0) ? sel : 14 - sel;
                ph    = (ph + 1) % 14;
                nsel  = (ph <= 7) ? ph : 14 - ph;
                ndir  = (ph >= 8 || ph == 0);
                nwrap = (ph == 0);
            end
            default: ;
        endcase
    endtask

    task automatic model_tick(input int k);
        int  s, ns;
        bit  d, nd, w;
`ifdef SCAN_SKIP_EN
        bit  found, wacc;
        s = m_sel[k]; d = m_dir[k]; found = 1'b0; wacc = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ref_step(s, d, mode, ns, nd, w);
            s = ns; d = nd; wacc = wacc | w;
            if (!found && !skip_mask[s]) begin
                found = 1'b1; m_sel[k] = s; m_dir[k] = d; m_wrap[k] = wacc;
            end
        end
`else
        s = m_sel[k]; d = m_dir[k];
        ref_step(s, d, mode, ns, nd, w);
        m_sel[k] = ns; m_dir[k] = nd; m_wrap[k] = w;
`endif
        m_step[k] = 1'b1;
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            m_step[k] = 1'b0;
            m_wrap[k] = 1'b0;
            if (rst) begin
                m_sel[k] = 0; m_dir[k] = 1'b0; m_cnt[k] = 0;
            end else if (load) begin
                m_sel[k] = int'(load_val); m_dir[k] = (load_val == 3'd7); m_cnt[k] = 0;
            end else if (en) begin
                m_cnt[k] = (m_cnt[k] + 1) % m_div[k];
                if (m_cnt[k] == 0) model_tick(k);
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("sel_div4",  {5'b0, s2_a, s1_a, s0_a}, 8'(m_sel[0]));
        check("step_div4", {7'b0, step_a}, {7'b0, m_step[0]});
        check("wrap_div4", {7'b0, wrap_a}, {7'b0, m_wrap[0]});
        check("dir_div4",  {7'b0, dir_a},  {7'b0, m_dir[0]});
        check("sel_div1",  {5'b0, s2_b, s1_b, s0_b}, 8'(m_sel[1]));
        check("step_div1", {7'b0, step_b}, {7'b0, m_step[1]});
        check("wrap_div1", {7'b0, wrap_b}, {7'b0, m_wrap[1]});
        check("dir_div1",  {7'b0, dir_b},  {7'b0, m_dir[1]});
    endtask

    task automatic do_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all();
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0; load_val = 3'd0;
`ifdef SCAN_SKIP_EN
        skip_mask = 8'h00;
`endif
        for (int k = 0; k < 2; k++) begin
            m_sel[k] = 0; m_dir[k] = 1'b0; m_step[k] = 1'b0; m_wrap[k] = 1'b0; m_cnt[k] = 0;
        end

        // Reset state, then count up through a full wrap.
        do_cycles(2);
        rst = 1'b0; en = 1'b1; mode = 2'b00;
        do_cycles(40);

        // Down from 2 through the 0->7 wrap.
        load = 1'b1; load_val = 3'd2;
        do_cycles(1);
        load = 1'b0; mode = 2'b01;
        do_cycles(20);

        // Ping-pong from reset over more than a full loop.
        rst = 1'b1;
        do_cycles(1);
        rst = 1'b0; mode = 2'b10;
        do_cycles(64);

        // Load 7 into ping-pong: next step must head down to 6.
        load = 1'b1; load_val = 3'd7;
        do_cycles(1);
        load = 1'b0;
        do_cycles(12);

        // Load coincident with a DIV=4 tick discards that tick.
        mode = 2'b00;
        for (int i = 0; i < 8 && m_cnt[0] != 3; i++) do_cycles(1);
        load = 1'b1; load_val = 3'd5;
        do_cycles(1);
        load = 1'b0;
        do_cycles(10);

        // Pause at cnt=2 for 10 cycles, then resume.
        for (int i = 0; i < 8 && m_cnt[0] != 2; i++) do_cycles(1);
        en = 1'b0;
        do_cycles(10);
        en = 1'b1;
        do_cycles(6);

        // Hold mode still pulses step.
        mode = 2'b11;
        do_cycles(12);

        // Reset in the middle of a run.
        mode = 2'b01;
        do_cycles(5);
        rst = 1'b1;
        do_cycles(1);
        rst = 1'b0;
        do_cycles(3);

`ifdef SCAN_SKIP_EN
        rst = 1'b1;
        do_cycles(1);
        rst = 1'b0; mode = 2'b00; skip_mask = 8'b0101_0100;
        do_cycles(30);
        skip_mask = 8'hFE; load = 1'b1; load_val = 3'd0;
        do_cycles(1);
        load = 1'b0;
        do_cycles(12);
        skip_mask = 8'h00;
`endif

        // Randomised traffic across all controls.
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            load     = ($urandom_range(0, 19) == 0);
            load_val = 3'($urandom_range(0, 7));
            rst      = ($urandom_range(0, 99) == 0);
`ifdef SCAN_SKIP_EN
            if ($urandom_range(0, 31) == 0) skip_mask = 8'($urandom_range(0, 255));
`endif
            do_cycles(1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
